// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The stage, its buffering FIFO and the bus interface all import this package.
package if_stage_pkg;

  localparam int MAX_DEPTH = 4;
  localparam int PTR_W     = 2;
  localparam int CNT_W     = 3;

  typedef logic [31:0]      inst_addr_t;
  typedef logic [31:0]      inst_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam inst_t NOP_INST = 32'h0000_0013;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

  // FIFO pointers wrap at the configured depth, not at the pointer width.
  function automatic ptr_t ptr_inc(ptr_t p, int depth);
    return (int'(p) == depth - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic inst_addr_t align_word(inst_addr_t a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals.
// master is the fetch stage side; slave is the memory/decode environment side.
interface if_stage_if;
  import if_stage_pkg::*;

  logic       mem_req;
  inst_addr_t mem_addr;
  logic       mem_gnt;
  logic       mem_rvalid;
  inst_t      mem_rdata;

  logic       id_valid;
  inst_addr_t id_pc;
  inst_t      id_inst;
  logic       id_ready;

  logic       redirect_valid;
  inst_addr_t redirect_pc;

  modport master (
    output mem_req, mem_addr, id_valid, id_pc, id_inst,
    input  mem_gnt, mem_rvalid, mem_rdata, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, id_valid, id_pc, id_inst,
    output mem_gnt, mem_rvalid, mem_rdata, id_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/if_fifo.sv
// DEPTH-entry FIFO of {pc, inst} pairs between instruction memory and decode.
// Clear flushes all entries in one cycle; storage itself is not reset.
module if_fifo
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output cnt_t         count
);

  fetch_entry_t mem_q [MAX_DEPTH];
  fetch_entry_t mem_d [MAX_DEPTH];
  ptr_t         head_q, head_d;
  ptr_t         tail_q, tail_d;
  cnt_t         count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_entry;
        tail_d        = ptr_inc(tail_q, DEPTH);
      end
      if (pop) begin
        head_d = ptr_inc(head_q, DEPTH);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order fetches with credit-based
// flow control, buffers returned words and flushes everything on a redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);

  localparam logic [CNT_W:0] CREDIT_LIMIT = DEPTH[CNT_W:0];

  inst_addr_t   fetch_pc_q, fetch_pc_d;
  inst_addr_t   resp_pc_q, resp_pc_d;
  cnt_t         inflight_q, inflight_d;
  cnt_t         discard_q, discard_d;

  cnt_t         fifo_count;
  fetch_entry_t fifo_head;
  fetch_entry_t push_entry;
  logic         credit_ok;
  logic         grant;
  logic         keep;
  logic         pop;
  logic         clear;

  // Buffered words count against credit even if popped this cycle, so a push never overflows.
  assign credit_ok   = ({1'b0, inflight_q} + {1'b0, fifo_count}) < CREDIT_LIMIT;
  assign bus.mem_req  = rst && !bus.redirect_valid && credit_ok;
  assign bus.mem_addr = fetch_pc_q;
  assign grant        = bus.mem_req && bus.mem_gnt;

  assign keep       = bus.mem_rvalid && (discard_q == '0) && !bus.redirect_valid;
  assign clear      = bus.redirect_valid;
  assign push_entry = '{pc: resp_pc_q, inst: bus.mem_rdata};

  assign bus.id_valid = (fifo_count != '0) && !bus.redirect_valid;
  assign bus.id_pc    = bus.id_valid ? fifo_head.pc : '0;
  assign bus.id_inst  = bus.id_valid ? fifo_head.inst : NOP_INST;
  assign pop          = bus.id_valid && bus.id_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    case ({grant, bus.mem_rvalid})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    if (bus.mem_rvalid && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end

    if (keep) begin
      resp_pc_d = resp_pc_q + 32'd4;
    end

    // Everything still outstanding after this cycle belongs to the old stream.
    if (bus.redirect_valid) begin
      fetch_pc_d = align_word(bus.redirect_pc);
      resp_pc_d  = align_word(bus.redirect_pc);
      discard_d  = inflight_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (keep),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (clear),
    .head       (fifo_head),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: a memory responder plus a stream-level
// model of which PCs decode should see, checked by an independent monitor.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam int         DEPTH    = 2;
  localparam inst_addr_t RESET_PC = 32'h0000_0000;

  typedef struct {
    inst_addr_t addr;
    int         due;
  } mem_txn_t;

  logic clk;
  logic rst;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cycle  = 0;
  int           pops   = 0;
  mem_txn_t     pending[$];
  fetch_entry_t exp_q[$];
  inst_addr_t   popped_log[$];
  int           stale_left = 0;
  inst_addr_t   model_pc   = RESET_PC;

  int gnt_pct   = 100;
  int ready_pct = 100;
  int lat_min   = 1;
  int lat_max   = 1;

  function automatic inst_t mem_word(inst_addr_t a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Words decode still has to see = all expected minus the non-stale ones still in flight.
  function automatic int model_buffered();
    return exp_q.size() - (pending.size() - stale_left);
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    pending.delete();
    exp_q.delete();
    stale_left = 0;
    model_pc   = RESET_PC;
  endtask

  task automatic zero_inputs();
    bus.mem_gnt        = 1'b0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_rdata      = '0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  // One cycle: drive inputs on the falling edge, then record grants and responses.
  task automatic applyStimulus(input bit redir, input inst_addr_t target);
    logic rv;
    logic grant;
    @(negedge clk);
    cycle++;
    bus.id_ready       = ($urandom_range(99) < ready_pct);
    bus.mem_gnt        = ($urandom_range(99) < gnt_pct);
    bus.redirect_valid = redir;
    bus.redirect_pc    = target;
    rv = (pending.size() > 0) && (pending[0].due <= cycle);
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rv ? mem_word(pending[0].addr) : $urandom;
    #2;
    grant = bus.mem_req && bus.mem_gnt;
    if (rv) begin
      void'(pending.pop_front());
      if (stale_left > 0) stale_left--;
    end
    if (redir) begin
      exp_q.delete();
      stale_left = pending.size();
      model_pc   = align_word(target);
    end
    if (grant) begin
      check_eq("grant_addr", bus.mem_addr, model_pc);
      exp_q.push_back('{pc: model_pc, inst: mem_word(model_pc)});
      pending.push_back('{addr: bus.mem_addr, due: cycle + $urandom_range(lat_max, lat_min)});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic checkOutput();
    int   buffered;
    logic exp_req;
    logic exp_valid;
    buffered  = model_buffered();
    exp_req   = !bus.redirect_valid && ((pending.size() + buffered) < DEPTH);
    exp_valid = !bus.redirect_valid && (buffered > 0);
    check_eq("mem_req", 32'(bus.mem_req), 32'(exp_req));
    check_eq("id_valid", 32'(bus.id_valid), 32'(exp_valid));
    if (bus.id_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL id_unexpected actual pc=%h expected no output", bus.id_pc);
      end else begin
        check_eq("id_pc", bus.id_pc, exp_q[0].pc);
        check_eq("id_inst", bus.id_inst, exp_q[0].inst);
        if (bus.id_ready) begin
          popped_log.push_back(bus.id_pc);
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end else begin
      check_eq("id_inst_nop", bus.id_inst, NOP_INST);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b1) checkOutput();
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         start_pops;
    bit         found;
    inst_addr_t target;

    rst = 1'b0;
    zero_inputs();
    reset_model();
    #1;
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check_eq("rst_mem_addr", bus.mem_addr, RESET_PC);
    check_eq("rst_id_valid", 32'(bus.id_valid), 32'h0);
    check_eq("rst_id_pc", bus.id_pc, 32'h0);
    check_eq("rst_id_inst", bus.id_inst, NOP_INST);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Decode stall straight out of reset: FIFO fills and holds PC 0.
    gnt_pct = 100; ready_pct = 0; lat_min = 1; lat_max = 1;
    repeat (10) applyStimulus(1'b0, '0);
    check_eq("stall_req_drop", 32'(bus.mem_req), 32'h0);
    check_eq("stall_valid", 32'(bus.id_valid), 32'h1);
    check_eq("stall_hold_pc", bus.id_pc, RESET_PC);

    // Straight-line fetch with decode always ready.
    ready_pct  = 100;
    start_pops = pops;
    repeat (30) applyStimulus(1'b0, '0);
    check_eq("throughput", 32'((pops - start_pops) >= 15), 32'h1);

    // Redirect with two slow fetches outstanding.
    lat_min = 3; lat_max = 3;
    repeat (6) applyStimulus(1'b0, '0);
    applyStimulus(1'b1, 32'h0000_1002);
    check_eq("redir_valid_low", 32'(bus.id_valid), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, '0);
      if (bus.id_valid === 1'b1) begin
        found = 1'b1;
        check_eq("redir_first_pc", bus.id_pc, 32'h0000_1000);
      end
    end
    if (!found) check_eq("redir_first_timeout", 32'h0, 32'h1);

    // Redirect landing on a cycle with a returning word and a pop.
    lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if ((pending.size() > 0) && (pending[0].due <= cycle + 1) &&
          (stale_left == 0) && (model_buffered() > 0)) begin
        found = 1'b1;
        start_pops = pops;
        applyStimulus(1'b1, 32'h0000_2000);
        check_eq("coinc_no_pop", 32'(pops - start_pops), 32'h0);
        applyStimulus(1'b0, '0);
        check_eq("coinc_fifo_empty", 32'(bus.id_valid), 32'h0);
      end else begin
        applyStimulus(1'b0, '0);
      end
    end
    if (!found) check_eq("coinc_timeout", 32'h0, 32'h1);

    // PC wrap across the top of the address space.
    repeat (5) applyStimulus(1'b0, '0);
    popped_log.delete();
    applyStimulus(1'b1, 32'hFFFF_FFFC);
    repeat (12) applyStimulus(1'b0, '0);
    if (popped_log.size() >= 2) begin
      check_eq("wrap_pc0", popped_log[0], 32'hFFFF_FFFC);
      check_eq("wrap_pc1", popped_log[1], 32'h0000_0000);
    end else begin
      check_eq("wrap_count", popped_log.size(), 32'd2);
    end

    // Reset asserted with the FIFO full.
    ready_pct = 0;
    repeat (8) applyStimulus(1'b0, '0);
    check_eq("full_before_reset", 32'(bus.id_valid), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    zero_inputs();
    #1;
    reset_model();
    check_eq("midrst_id_valid", 32'(bus.id_valid), 32'h0);
    check_eq("midrst_id_inst", bus.id_inst, NOP_INST);
    check_eq("midrst_mem_req", 32'(bus.mem_req), 32'h0);
    check_eq("midrst_mem_addr", bus.mem_addr, RESET_PC);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("post_rst_req", 32'(bus.mem_req), 32'h1);
    check_eq("post_rst_addr", bus.mem_addr, RESET_PC);
    ready_pct = 100;
    repeat (10) applyStimulus(1'b0, '0);

    // Randomized traffic with occasional redirects.
    gnt_pct = 70; ready_pct = 60; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 4) begin
        target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        applyStimulus(1'b1, target);
      end else begin
        applyStimulus(1'b0, '0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
